axis_detect_tx: RTL and testbench
=================================

# axis_detect_tx

AXI-Stream master that returns HOG/SVM detection results to the host side of the fabric. It is the transmit counterpart of the frame-ingest AXI-Stream slave in `image_processor`. It collects the per-window `is_person` decisions of one frame into a window bitmap, slices the bitmap into 256-bit beats, and streams them out with TLAST on the final beat of each frame. A 2-entry beat FIFO absorbs downstream stalls, because the detector cannot be back-pressured.

## Interface
Clock is `s_aclk`. Reset is `s_aresetn`: synchronous, active-low.

Parameters:
- `SW_W`, 11: slide-window id width.
- `SW_NUM`, 495: windows per frame; must satisfy 1 ≤ `SW_NUM` ≤ 2^`SW_W`.
- `AXIS_TDATA_W`, 256: beat width; one bit per window.
- `AXIS_TKEEP_W`, `AXIS_TDATA_W`/8: TKEEP width.
- `AXIS_TSTRB_W`, `AXIS_TDATA_W`/8: TSTRB width.
- `AXIS_TID_W`, 2: TID width.
- `AXIS_TDEST_W`, 1: TDEST width.
- `TID_VAL`, 0: constant driven on TID.
- `TDEST_VAL`, 0: constant driven on TDEST.

Ports:
- `s_aclk`, in, 1: clock.
- `s_aresetn`, in, 1: synchronous active-low reset.
- `i_valid`, in, 1: one detection result is presented this cycle.
- `i_is_person`, in, 1: decision for the current window.
- `i_sw_id`, in, `SW_W`: id of the current window.
- `i_clr_flags`, in, 1: clears the sticky flags.
- `m_tid_o`, out, `AXIS_TID_W`: stream id, always `TID_VAL`.
- `m_tdest_o`, out, `AXIS_TDEST_W`: stream destination, always `TDEST_VAL`.
- `m_tdata_o`, out, `AXIS_TDATA_W`: bitmap slice.
- `m_tkeep_o`, out, `AXIS_TKEEP_W`: all ones.
- `m_tstrb_o`, out, `AXIS_TSTRB_W`: byte mask of bytes that carry window bits.
- `m_tlast_o`, out, 1: marks the last beat of a frame.
- `m_tvalid_o`, out, 1: beat available.
- `m_tready_i`, in, 1: downstream accepts the beat.
- `frame_done_o`, out, 1: one-cycle pulse when a frame's last beat is pushed.
- `ovf_o`, out, 1: sticky; a beat was dropped.
- `seq_err_o`, out, 1: sticky; `i_sw_id` differed from the expected window.

## Operation
Derived constants:
- NBEAT = ceil(`SW_NUM`/256).
- LASTBITS = `SW_NUM` − 256·(NBEAT−1).

Accumulator state:
- `win_cnt` (`SW_W` bits), `bit_idx` (8 bits), and a 256-bit `acc`.
- All three reset to 0.

On each cycle with `i_valid`=1:
- Write `acc[bit_idx]` ← `i_is_person`.
- The bit position always comes from `win_cnt`, not `i_sw_id`.
- If `i_sw_id` ≠ `win_cnt`, set `seq_err_o`.

Beat completion happens when `bit_idx`=255 or `win_cnt`=`SW_NUM`−1. On completion:
- Push the entry {data = `acc` with the new bit, last = (`win_cnt`=`SW_NUM`−1)}.
- Bits above the written position are 0, because `acc` was cleared.
- Clear `acc` and set `bit_idx`=0.
- If last: set `win_cnt`=0 and pulse `frame_done_o`.
- Otherwise (or when the beat is not complete): increment `win_cnt` and `bit_idx`.

Beat FIFO:
- 2 entries; head entry registered.
- A push when full and not popping in the same cycle drops the incoming beat and sets `ovf_o`.
- Accumulator counters advance regardless, so frame alignment is preserved.
- A push and a pop in the same cycle while full is accepted; occupancy stays 2.
- A push and a pop in the same cycle with 1 entry keeps occupancy at 1, and the new entry becomes head next cycle.

Output signals:
- `m_tvalid_o` = FIFO not empty.
- `m_tdata_o` and `m_tlast_o` come from the head entry.
- Pop occurs when `m_tvalid_o` and `m_tready_i` are both 1.
- `m_tstrb_o` = all ones, except on a last beat, where it is (1<<ceil(LASTBITS/8))−1.
- `m_tkeep_o` = all ones. `m_tid_o` and `m_tdest_o` are constants.

Sticky flags:
- Cleared only by reset or `i_clr_flags`.
- If `i_clr_flags` and a set event occur in the same cycle, the set wins.

## Timing
- Reset values: `m_tvalid_o`, `m_tlast_o`, `m_tdata_o`, `m_tstrb_o`, `frame_done_o`, `ovf_o` and `seq_err_o` are all 0. `m_tkeep_o`, `m_tid_o` and `m_tdest_o` hold their constants.
- Latency: the result that completes a beat at cycle N gives `m_tvalid_o`=1 at N+1, if the FIFO was empty. `frame_done_o` is high at N+1.
- AXIS rules:
  - Once `m_tvalid_o` rises, `m_tdata_o`, `m_tlast_o` and `m_tstrb_o` stay stable until the pop.
  - `m_tvalid_o` never drops without a handshake.
  - `m_tvalid_o` does not depend on `m_tready_i`.
- Back-to-back `i_valid` on every cycle is supported. Full-rate pop gives one beat per cycle.
- Reset mid-frame discards the partial `acc` and all FIFO entries. The next result is treated as window 0.

## Test plan
- **Frame content:** frame of 495 results with `is_person`=1 at ids 0, 255, 256, 494; `m_tready_i`=1 → beat0 has bits 0 and 255 set, tlast=0, tstrb all ones; beat1 has bits 0 and 238 set, tlast=1, tstrb=0x3FFFFFFF; one `frame_done_o` pulse.
- **Overflow:** `m_tready_i`=0 through 1.5 frames (3 beats pushed) → FIFO holds beats 0 and 1; third beat dropped; `ovf_o`=1; beat0 data stable for the entire stall.
- **Full, push and pop together:** FIFO full, then `m_tready_i`=1 in the same cycle as a beat completion → no drop, `ovf_o` stays 0, beats emerge in order.
- **Sequence error:** skip id 10 (send 9 then 11) → `seq_err_o`=1 at the next cycle; id 11's bit lands at position 10; `i_clr_flags` clears the flag.
- **Reset mid-frame:** assert `s_aresetn`=0 after 100 results, then send a fresh frame → all outputs return to reset values; the new frame's beat0 reflects only post-reset results.
- **Throughput:** full-rate `i_valid` with 3 consecutive frames at `m_tready_i`=1 → 6 beats, tlast on beats 2, 4 and 6, no ovf.

Source files
------------

// File: rtl/axis_detect_tx_if.sv
// AXI-Stream bus carrying detection bitmap beats from axis_detect_tx to the host fabric.
interface axis_detect_tx_if #(
   parameter int AXIS_TDATA_W = 256,
   parameter int AXIS_TKEEP_W = AXIS_TDATA_W / 8,
   parameter int AXIS_TSTRB_W = AXIS_TDATA_W / 8,
   parameter int AXIS_TID_W   = 2,
   parameter int AXIS_TDEST_W = 1
);
   logic [AXIS_TID_W-1:0]   m_tid_o;
   logic [AXIS_TDEST_W-1:0] m_tdest_o;
   logic [AXIS_TDATA_W-1:0] m_tdata_o;
   logic [AXIS_TKEEP_W-1:0] m_tkeep_o;
   logic [AXIS_TSTRB_W-1:0] m_tstrb_o;
   logic                    m_tlast_o;
   logic                    m_tvalid_o;
   logic                    m_tready_i;

   modport master (
      output m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
      input  m_tready_i
   );

   modport slave (
      input  m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
      output m_tready_i
   );
endinterface

// File: rtl/axis_detect_tx.sv
// Packs per-window person decisions into a frame bitmap, slices it into beats and
// streams them out over AXI-Stream through a 2-entry FIFO that soaks up stalls.
module axis_detect_tx #(
   parameter int SW_W         = 11,
   parameter int SW_NUM       = 495,
   parameter int AXIS_TDATA_W = 256,
   parameter int AXIS_TKEEP_W = AXIS_TDATA_W / 8,
   parameter int AXIS_TSTRB_W = AXIS_TDATA_W / 8,
   parameter int AXIS_TID_W   = 2,
   parameter int AXIS_TDEST_W = 1,
   parameter logic [AXIS_TID_W-1:0]   TID_VAL   = '0,
   parameter logic [AXIS_TDEST_W-1:0] TDEST_VAL = '0
) (
   input  logic                s_aclk,
   input  logic                s_aresetn,
   input  logic                i_valid,
   input  logic                i_is_person,
   input  logic [SW_W-1:0]     i_sw_id,
   input  logic                i_clr_flags,
   axis_detect_tx_if.master    m_axis,
   output logic                frame_done_o,
   output logic                ovf_o,
   output logic                seq_err_o
);
   localparam int BIT_W     = $clog2(AXIS_TDATA_W);
   localparam int NBEAT     = (SW_NUM + AXIS_TDATA_W - 1) / AXIS_TDATA_W;
   localparam int LASTBITS  = SW_NUM - AXIS_TDATA_W * (NBEAT - 1);
   localparam int LASTBYTES = (LASTBITS + 7) / 8;
   localparam logic [AXIS_TSTRB_W:0] LAST_STRB_EXT =
      ((AXIS_TSTRB_W+1)'(1) << LASTBYTES) - (AXIS_TSTRB_W+1)'(1);
   localparam logic [AXIS_TSTRB_W-1:0] LAST_STRB = LAST_STRB_EXT[AXIS_TSTRB_W-1:0];
   localparam logic [SW_W-1:0] LAST_WIN = SW_W'(SW_NUM - 1);

   logic [SW_W-1:0]         winCnt_q, winCnt_d;
   logic [BIT_W-1:0]        bitIdx_q, bitIdx_d;
   logic [AXIS_TDATA_W-1:0] acc_q, acc_d;
   logic [AXIS_TDATA_W-1:0] beatData;
   logic                    isLastWin, beatDone;

   logic [AXIS_TDATA_W-1:0] headData_q, headData_d, tailData_q, tailData_d;
   logic                    headLast_q, headLast_d, tailLast_q, tailLast_d;
   logic [1:0]              count_q, count_d;
   logic                    push, pop, drop;

   logic                    frameDone_q, frameDone_d;
   logic                    ovf_q, ovf_d;
   logic                    seqErr_q, seqErr_d;

   // Accumulator: slot the decision at the position implied by the window counter,
   // and hand off a finished beat when the slice is full or the frame ends.
   always_comb begin
      beatData           = acc_q;
      beatData[bitIdx_q] = i_is_person;
      isLastWin          = (winCnt_q == LAST_WIN);
      beatDone           = i_valid && ((bitIdx_q == {BIT_W{1'b1}}) || isLastWin);
      acc_d              = acc_q;
      winCnt_d           = winCnt_q;
      bitIdx_d           = bitIdx_q;
      if (i_valid) begin
         if (beatDone) begin
            acc_d    = '0;
            bitIdx_d = '0;
            winCnt_d = isLastWin ? '0 : winCnt_q + 1'b1;
         end else begin
            acc_d    = beatData;
            winCnt_d = winCnt_q + 1'b1;
            bitIdx_d = bitIdx_q + 1'b1;
         end
      end
   end

   // Beat FIFO: head entry drives the bus, tail only fills when the head is stalled;
   // a completed beat arriving with both slots busy and no pop is lost.
   always_comb begin
      push       = beatDone;
      pop        = (count_q != 2'd0) && m_axis.m_tready_i;
      drop       = push && (count_q == 2'd2) && !pop;
      headData_d = headData_q;
      headLast_d = headLast_q;
      tailData_d = tailData_q;
      tailLast_d = tailLast_q;
      count_d    = count_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               headData_d = beatData;
               headLast_d = isLastWin;
               count_d    = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               headData_d = beatData;
               headLast_d = isLastWin;
            end else if (push) begin
               tailData_d = beatData;
               tailLast_d = isLastWin;
               count_d    = 2'd2;
            end else if (pop) begin
               count_d    = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               headData_d = tailData_q;
               headLast_d = tailLast_q;
               if (push) begin
                  tailData_d = beatData;
                  tailLast_d = isLastWin;
               end else begin
                  count_d = 2'd1;
               end
            end
         end
      endcase
      frameDone_d = beatDone && isLastWin;
      ovf_d       = drop ? 1'b1 : (i_clr_flags ? 1'b0 : ovf_q);
      seqErr_d    = (i_valid && (i_sw_id != winCnt_q)) ? 1'b1 : (i_clr_flags ? 1'b0 : seqErr_q);
   end

   // State registers; reset throws away any partial bitmap and queued beats.
   always_ff @(posedge s_aclk) begin
      if (!s_aresetn) begin
         winCnt_q    <= '0;
         bitIdx_q    <= '0;
         acc_q       <= '0;
         headData_q  <= '0;
         headLast_q  <= 1'b0;
         tailData_q  <= '0;
         tailLast_q  <= 1'b0;
         count_q     <= 2'd0;
         frameDone_q <= 1'b0;
         ovf_q       <= 1'b0;
         seqErr_q    <= 1'b0;
      end else begin
         winCnt_q    <= winCnt_d;
         bitIdx_q    <= bitIdx_d;
         acc_q       <= acc_d;
         headData_q  <= headData_d;
         headLast_q  <= headLast_d;
         tailData_q  <= tailData_d;
         tailLast_q  <= tailLast_d;
         count_q     <= count_d;
         frameDone_q <= frameDone_d;
         ovf_q       <= ovf_d;
         seqErr_q    <= seqErr_d;
      end
   end

   assign m_axis.m_tvalid_o = (count_q != 2'd0);
   assign m_axis.m_tdata_o  = headData_q;
   assign m_axis.m_tlast_o  = headLast_q;
   assign m_axis.m_tstrb_o  = (count_q == 2'd0) ? '0 :
                              (headLast_q ? LAST_STRB : {AXIS_TSTRB_W{1'b1}});
   assign m_axis.m_tkeep_o  = {AXIS_TKEEP_W{1'b1}};
   assign m_axis.m_tid_o    = TID_VAL;
   assign m_axis.m_tdest_o  = TDEST_VAL;
   assign frame_done_o      = frameDone_q;
   assign ovf_o             = ovf_q;
   assign seq_err_o         = seqErr_q;
endmodule

// File: tb/tb_axis_detect_tx.sv
// Randomised scoreboard bench for axis_detect_tx: a frame-level bitmap model predicts beats
// and flags, and a monitor compares every handshaken beat against the expected queue.
module tb_axis_detect_tx;
   localparam int SW_W   = 11;
   localparam int SW_NUM = 495;
   localparam int DW     = 256;
   localparam int KW     = DW / 8;
   localparam int IDW    = 2;
   localparam int DSW    = 1;
   localparam logic [IDW-1:0] TID_C   = 2'd2;
   localparam logic [DSW-1:0] TDEST_C = 1'b1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [KW-1:0] strb;
   } beat_t;

   logic            s_aclk = 1'b0;
   logic            s_aresetn = 1'b0;
   logic            i_valid = 1'b0;
   logic            i_is_person = 1'b0;
   logic [SW_W-1:0] i_sw_id = '0;
   logic            i_clr_flags = 1'b0;
   logic            frame_done_o, ovf_o, seq_err_o;

   axis_detect_tx_if #(.AXIS_TDATA_W(DW), .AXIS_TID_W(IDW), .AXIS_TDEST_W(DSW)) axisIf ();

   axis_detect_tx #(
      .SW_W(SW_W), .SW_NUM(SW_NUM), .AXIS_TDATA_W(DW), .AXIS_TID_W(IDW), .AXIS_TDEST_W(DSW),
      .TID_VAL(TID_C), .TDEST_VAL(TDEST_C)
   ) dut (
      .s_aclk(s_aclk), .s_aresetn(s_aresetn), .i_valid(i_valid), .i_is_person(i_is_person),
      .i_sw_id(i_sw_id), .i_clr_flags(i_clr_flags), .m_axis(axisIf),
      .frame_done_o(frame_done_o), .ovf_o(ovf_o), .seq_err_o(seq_err_o)
   );

   // Free-running 100 MHz clock.
   always #5 s_aclk = ~s_aclk;

   beat_t         sbQ[$];
   int            checksTotal = 0;
   int            checksPassed = 0;
   int            beatsSeen = 0;
   int            modelWin = 0;
   int            modelOcc = 0;
   bit            frameBits[SW_NUM];
   bit            expOvf = 1'b0;
   bit            expSeq = 1'b0;
   bit            expFd = 1'b0;
   logic [KW-1:0] lastStrb;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every beat taken by the sink must match the oldest expected beat, and a
   // stalled beat must keep its payload and valid until it is taken.
   logic          prevHold = 1'b0;
   logic [DW-1:0] prevData;
   logic          prevLast;
   logic [KW-1:0] prevStrb;
   beat_t         expBeat;
   always @(negedge s_aclk) begin
      if (!s_aresetn) begin
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("tvalid_held", DW'(axisIf.m_tvalid_o), DW'(1));
            checkOutput("tdata_stable", axisIf.m_tdata_o, prevData);
            checkOutput("tlast_stable", DW'(axisIf.m_tlast_o), DW'(prevLast));
            checkOutput("tstrb_stable", DW'(axisIf.m_tstrb_o), DW'(prevStrb));
         end
         if (axisIf.m_tvalid_o && axisIf.m_tready_i) begin
            if (sbQ.size() == 0) begin
               checksTotal++;
               $display("[TB] FAIL unexpected_beat: got beat %0h, expected none", axisIf.m_tdata_o);
            end else begin
               expBeat = sbQ.pop_front();
               checkOutput("beat_tdata", axisIf.m_tdata_o, expBeat.data);
               checkOutput("beat_tlast", DW'(axisIf.m_tlast_o), DW'(expBeat.last));
               checkOutput("beat_tstrb", DW'(axisIf.m_tstrb_o), DW'(expBeat.strb));
            end
            beatsSeen++;
            prevHold = 1'b0;
         end else if (axisIf.m_tvalid_o) begin
            prevHold = 1'b1;
            prevData = axisIf.m_tdata_o;
            prevLast = axisIf.m_tlast_o;
            prevStrb = axisIf.m_tstrb_o;
         end else begin
            prevHold = 1'b0;
         end
      end
   end

   // One cycle of stimulus; the model decides what the frame bitmap beat looks like,
   // whether the two-deep buffer has room, and what the sticky flags should read.
   task automatic applyStimulus(input bit valid, input bit isPerson, input int swId, input bit ready, input bit clr);
      bit    pop, done, drop, setSeq, endFrame;
      int    base;
      beat_t b;
      i_valid             = valid;
      i_is_person         = isPerson;
      i_sw_id             = SW_W'(swId);
      axisIf.m_tready_i   = ready;
      i_clr_flags         = clr;
      pop = (modelOcc > 0) && ready;
      done = 1'b0; drop = 1'b0; setSeq = 1'b0; endFrame = 1'b0;
      if (valid) begin
         setSeq = (swId != modelWin);
         frameBits[modelWin] = isPerson;
         endFrame = (modelWin == SW_NUM - 1);
         done = ((modelWin % DW) == DW - 1) || endFrame;
         if (done) begin
            base = (modelWin / DW) * DW;
            b.data = '0;
            for (int i = 0; i < DW; i++)
               if (base + i <= modelWin) b.data[i] = frameBits[base + i];
            b.last = endFrame;
            b.strb = endFrame ? lastStrb : '1;
            if (modelOcc == 2 && !pop) drop = 1'b1;
            else begin
               sbQ.push_back(b);
               modelOcc++;
            end
         end
         if (endFrame) begin
            modelWin = 0;
            for (int i = 0; i < SW_NUM; i++) frameBits[i] = 1'b0;
         end else begin
            modelWin++;
         end
      end
      if (pop) modelOcc--;
      expFd  = done && endFrame;
      expOvf = drop ? 1'b1 : (clr ? 1'b0 : expOvf);
      expSeq = setSeq ? 1'b1 : (clr ? 1'b0 : expSeq);
      @(posedge s_aclk);
      #1;
      checkOutput("frame_done", DW'(frame_done_o), DW'(expFd));
      checkOutput("ovf", DW'(ovf_o), DW'(expOvf));
      checkOutput("seq_err", DW'(seq_err_o), DW'(expSeq));
      checkOutput("tvalid", DW'(axisIf.m_tvalid_o), DW'(modelOcc > 0));
   endtask

   task automatic sendResult(input bit isPerson, input bit ready);
      applyStimulus(1'b1, isPerson, modelWin, ready, 1'b0);
   endtask

   task automatic idle(input int n, input bit ready);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, ready, 1'b0);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_tvalid", DW'(axisIf.m_tvalid_o), DW'(0));
      checkOutput("rst_tlast", DW'(axisIf.m_tlast_o), DW'(0));
      checkOutput("rst_tdata", axisIf.m_tdata_o, '0);
      checkOutput("rst_tstrb", DW'(axisIf.m_tstrb_o), DW'(0));
      checkOutput("rst_frame_done", DW'(frame_done_o), DW'(0));
      checkOutput("rst_ovf", DW'(ovf_o), DW'(0));
      checkOutput("rst_seq_err", DW'(seq_err_o), DW'(0));
      checkOutput("rst_tkeep", DW'(axisIf.m_tkeep_o), DW'({KW{1'b1}}));
      checkOutput("rst_tid", DW'(axisIf.m_tid_o), DW'(TID_C));
      checkOutput("rst_tdest", DW'(axisIf.m_tdest_o), DW'(TDEST_C));
   endtask

   task automatic applyReset(input int cycles);
      s_aresetn = 1'b0;
      i_valid = 1'b0;
      i_clr_flags = 1'b0;
      axisIf.m_tready_i = 1'b0;
      sbQ.delete();
      modelOcc = 0;
      modelWin = 0;
      for (int i = 0; i < SW_NUM; i++) frameBits[i] = 1'b0;
      expOvf = 1'b0; expSeq = 1'b0; expFd = 1'b0;
      repeat (cycles) @(posedge s_aclk);
      #1;
      checkResetValues();
      s_aresetn = 1'b1;
   endtask

   // Watchdog so a wedged run still ends with a report.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nbeat, lastBits, startSeen;
      nbeat = (SW_NUM + DW - 1) / DW;
      lastBits = SW_NUM - DW * (nbeat - 1);
      lastStrb = '0;
      for (int i = 0; i < (lastBits + 7) / 8; i++) lastStrb[i] = 1'b1;
      axisIf.m_tready_i = 1'b0;
      applyReset(3);

      // Frame content with persons at 0, 255, 256 and the final window.
      for (int w = 0; w < SW_NUM; w++)
         sendResult((w == 0) || (w == 255) || (w == 256) || (w == SW_NUM - 1), 1'b1);
      idle(4, 1'b1);
      checkOutput("frame_drained", DW'(sbQ.size()), DW'(0));

      // Stall through 1.5 frames so the third beat is lost, then clear the flag.
      for (int k = 0; k < SW_NUM + DW; k++) sendResult(1'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
      // Finish the frame still stalled; the closing beat meets a pop while full.
      for (int k = 0; k < SW_NUM - DW - 1; k++) sendResult(1'($urandom), 1'b0);
      sendResult(1'b1, 1'b1);
      idle(5, 1'b1);
      checkOutput("ovf_drained", DW'(sbQ.size()), DW'(0));

      // Sequence error: window 10 is reported as id 11, then clear-vs-set priority.
      for (int w = 0; w < 10; w++) sendResult(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 11, 1'b1, 1'b0);
      for (int w = 11; w < 20; w++) sendResult(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 999, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
      while (modelWin != 0) sendResult(1'($urandom), 1'b1);
      idle(4, 1'b1);

      // Reset part way through a frame, then a fresh frame.
      for (int k = 0; k < 100; k++) sendResult(1'($urandom), 1'($urandom));
      applyReset(2);
      for (int w = 0; w < SW_NUM; w++) sendResult(1'($urandom), 1'b1);
      idle(4, 1'b1);

      // Throughput: three back-to-back frames at full rate.
      startSeen = beatsSeen;
      for (int k = 0; k < 3 * SW_NUM; k++) sendResult(1'($urandom), 1'b1);
      idle(4, 1'b1);
      checkOutput("throughput_beats", DW'(beatsSeen - startSeen), DW'(6));

      // Random traffic with random backpressure.
      for (int k = 0; k < 3 * SW_NUM; k++) begin
         if ($urandom_range(9, 0) < 7)
            applyStimulus(1'b1, 1'($urandom), modelWin, 1'($urandom), 1'b0);
         else
            applyStimulus(1'b0, 1'b0, 0, 1'($urandom), 1'b0);
      end
      idle(10, 1'b1);
      checkOutput("final_drained", DW'(sbQ.size()), DW'(0));

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end
endmodule
